// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: paces the fetch MMU with credit-based requests, buffers
// returned words in a small FIFO and presents decoded fields over valid/ready.
module instruction_decode_stage #(
    parameter int unsigned width   = 32,
    parameter int unsigned latency = 2,
    parameter int unsigned depth   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] fetch_instruction,
    output logic             fetch_next,
    output logic             fetch_stop,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [width-1:0] out_raw,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic             halted
);

    localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned cnt_w = $clog2(depth + 1);
    localparam int unsigned sum_w = cnt_w + 1;
    localparam logic [5:0]  halt_op = 6'h3F;

    logic [width-1:0]   mem [depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic [latency-1:0] req_pipe;
    logic [sum_w-1:0]   inflight;
    logic [width-1:0]   head;
    logic               push;
    logic               pop;
    logic               halt_xfer;
    logic               drop;

    // Outstanding MMU requests = set bits in the request pipe
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < latency; i++) begin
            inflight = inflight + sum_w'(req_pipe[i]);
        end
    end

    // Credit check guarantees every returning word has a free entry
    assign fetch_next = rst && !halted && !flush &&
                        ((sum_w'(count) + inflight) < sum_w'(depth));
    assign fetch_stop = halted;

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0) && !halted;
    assign pop       = out_valid && out_ready;
    assign halt_xfer = pop && (head[31:26] == halt_op);
    assign drop      = flush || halt_xfer;
    assign push      = req_pipe[latency-1] && !halted && !drop;

    // Decode fields come straight from the head entry and are zeroed when idle
    always_comb begin
        out_raw    = '0;
        out_opcode = '0;
        out_rd     = '0;
        out_rs1    = '0;
        out_rs2    = '0;
        out_imm    = '0;
        if (out_valid) begin
            out_raw    = head;
            out_opcode = head[31:26];
            out_rd     = head[25:21];
            out_rs1    = head[20:16];
            out_rs2    = head[15:11];
            out_imm    = {{16{head[15]}}, head[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            req_pipe <= '0;
            halted   <= 1'b0;
        end else begin
            if (drop) begin
                // Flush or HALT discards buffered words and in-flight requests
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                req_pipe <= '0;
            end else begin
                req_pipe <= (req_pipe << 1) | latency'(fetch_next);
                if (push) wr_ptr <= wr_ptr + ptr_w'(1);
                if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
                count <= count + cnt_w'(push) - cnt_w'(pop);
            end
            if (halt_xfer) halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fetch_instruction;
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage with a latency-2 MMU model.
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_instruction;
    logic        fetch_next;
    logic        fetch_stop;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_raw;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        halted;

    int total = 0;
    int bad = 0;
    int req_cnt = 0;
    int halt_at = -1;
    int base = 0;
    int mi0 = 0;
    int mi1 = 0;
    logic [1:0]  mv = 2'b00;
    logic [31:0] cyc = '0;
    logic [31:0] got[$];

    instruction_decode_stage #(.width(32), .latency(2), .depth(4)) dut (
        .clk(clk), .rst(rst), .fetch_instruction(fetch_instruction),
        .fetch_next(fetch_next), .fetch_stop(fetch_stop), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_raw(out_raw),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mmu_word(input int i, input int h);
        if (i == h) return 32'hFC000000;
        if (i == 0) return 32'h04210005;
        if (i == 1) return 32'h0862FFFF;
        return {6'((i % 50) + 1), 5'(i), 5'(i >> 5), 16'(i)};
    endfunction

    // MMU model: request index n appears on the bus two cycles after its strobe
    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        mv  <= {mv[0], fetch_next};
        mi1 <= mi0;
        mi0 <= req_cnt;
        if (fetch_next) req_cnt <= req_cnt + 1;
    end

    assign fetch_instruction = mv[1] ? mmu_word(mi1, halt_at) : (32'hBAD00000 ^ cyc);

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got.push_back(out_raw);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b0; out_ready = 1'b0; flush = 1'b0; halt_at = -1;
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        rst  = 1'b1;
        base = req_cnt;
    endtask

    task automatic check_seq(input string name, input int first, input int n_exp);
        total++;
        if (got.size() !== n_exp) begin
            bad++; $display("FAIL %s_count: got %0d want %0d", name, got.size(), n_exp);
        end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== mmu_word(first + k, halt_at)) begin
                bad++; $display("FAIL %s_word%0d: got %h want %h", name, k, got[k], mmu_word(first + k, halt_at));
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (fetch_next !== 1'b0) begin bad++; $display("FAIL rst_fetch_next: got %b want 0", fetch_next); end
        total++; if (fetch_stop !== 1'b0) begin bad++; $display("FAIL rst_fetch_stop: got %b want 0", fetch_stop); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if ({out_raw, out_opcode, out_rd, out_rs1, out_rs2, out_imm} !== '0) begin
            bad++; $display("FAIL rst_fields: raw %h imm %h want 0", out_raw, out_imm);
        end
        repeat (2) @(negedge clk);
        total++; if (fetch_next !== 1'b0) begin bad++; $display("FAIL rst_hold_fetch: got %b want 0", fetch_next); end
    endtask

    task automatic test_streaming();
        int t_req = -1;
        int t_val = -1;
        int seen2 = 0;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fetch_next && t_req < 0) t_req = k;
            if (out_valid && t_val < 0) t_val = k;
            if (out_valid && out_raw == 32'h0862FFFF) begin
                seen2 = 1;
                total++; if (out_opcode !== 6'd2) begin bad++; $display("FAIL dec_opcode: got %0d want 2", out_opcode); end
                total++; if (out_rd !== 5'd3) begin bad++; $display("FAIL dec_rd: got %0d want 3", out_rd); end
                total++; if (out_rs1 !== 5'd2) begin bad++; $display("FAIL dec_rs1: got %0d want 2", out_rs1); end
                total++; if (out_rs2 !== 5'd31) begin bad++; $display("FAIL dec_rs2: got %0d want 31", out_rs2); end
                total++; if (out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL dec_imm: got %h want ffffffff", out_imm); end
            end
        end
        @(posedge clk); #1; out_ready = 1'b0;
        total++; if (t_req !== 0) begin bad++; $display("FAIL stream_first_req: got %0d want 0", t_req); end
        total++; if (t_val - t_req !== 3) begin bad++; $display("FAIL stream_latency: got %0d want 3", t_val - t_req); end
        total++; if (seen2 !== 1) begin bad++; $display("FAIL stream_word2_seen: got %0d want 1", seen2); end
        check_seq("stream", base, 17);
    endtask

    task automatic test_backpressure();
        int n = 0;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fetch_next) n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL bp_requests: got %0d want 4", n); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_stall: got %b want 1", out_valid); end
        @(posedge clk); #1;
        total++; if (got.size() !== 0) begin bad++; $display("FAIL bp_no_xfer: got %0d want 0", got.size()); end
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
        @(posedge clk); #1; out_ready = 1'b0;
        check_seq("bp", base, 16);
    endtask

    task automatic test_halt();
        int found = 0;
        int viol = 0;
        apply_reset();
        halt_at = base + 3;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid && out_raw == 32'hFC000000) found = 1;
        end
        total++; if (found !== 1) begin bad++; $display("FAIL halt_seen: got %0d want 1", found); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_pre: got %b want 0", halted); end
        total++; if (out_opcode !== 6'h3F) begin bad++; $display("FAIL halt_opcode: got %h want 3f", out_opcode); end
        @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halted); end
        total++; if (fetch_stop !== 1'b1) begin bad++; $display("FAIL halt_stop: got %b want 1", fetch_stop); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %b want 0", out_valid); end
        total++; if (fetch_next !== 1'b0) begin bad++; $display("FAIL halt_fetch: got %b want 0", fetch_next); end
        repeat (10) begin
            @(negedge clk);
            if (out_valid || fetch_next || !halted) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL halt_frozen: got %0d bad cycles want 0", viol); end
        @(posedge clk); #1; out_ready = 1'b0;
        check_seq("halt", base, 4);
    endtask

    task automatic test_flush();
        apply_reset();
        repeat (4) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
        total++; if (fetch_next !== 1'b0) begin bad++; $display("FAIL flush_fetch: got %b want 0", fetch_next); end
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
        total++; if (fetch_next !== 1'b1) begin bad++; $display("FAIL flush_resume: got %b want 1", fetch_next); end
        repeat (12) @(negedge clk);
        @(posedge clk); #1; out_ready = 1'b0;
        check_seq("flush", base + 4, 10);
    endtask

    task automatic test_flush_halt();
        apply_reset();
        halt_at = base;
        repeat (4) @(posedge clk);
        #1; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        total++; if (out_raw !== 32'hFC000000) begin bad++; $display("FAIL fh_head: got %h want fc000000", out_raw); end
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL fh_halted: got %b want 1", halted); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fh_valid: got %b want 0", out_valid); end
        check_seq("fh", base, 1);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || fetch_next !== 1'b0) begin
            bad++; $display("FAIL mr_full: valid %b fetch %b want 1 0", out_valid, fetch_next);
        end
        #2; rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b want 0", out_valid); end
        total++; if (fetch_next !== 1'b0) begin bad++; $display("FAIL mr_fetch: got %b want 0", fetch_next); end
        total++; if ({out_raw, out_opcode, out_rd, out_rs1, out_rs2, out_imm} !== '0) begin
            bad++; $display("FAIL mr_fields: raw %h imm %h want 0", out_raw, out_imm);
        end
        total++; if (halted !== 1'b0 || fetch_stop !== 1'b0) begin
            bad++; $display("FAIL mr_halted: halted %b stop %b want 0 0", halted, fetch_stop);
        end
        @(posedge clk); @(posedge clk); #1;
        got.delete();
        rst = 1'b1; base = req_cnt; out_ready = 1'b1;
        @(negedge clk);
        total++; if (fetch_next !== 1'b1) begin bad++; $display("FAIL mr_restart: got %b want 1", fetch_next); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_empty: got %b want 0", out_valid); end
        repeat (8) @(negedge clk);
        @(posedge clk); #1; out_ready = 1'b0;
        check_seq("mr", base, 6);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_halt();
        test_flush();
        test_flush_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Downstream consumer of the instruction fetch MMU: it paces the MMU through its `next` strobe and captures the returned instructions into a small skid buffer. It splits each instruction into decoded fields and hands them to the execute stage over a valid/ready handshake. It also detects HALT, which freezes fetch through the MMU `stop` input, and supports a pipeline flush that drops all buffered and in-flight instructions.

## Interface

- `width`, 32: instruction width; must be 32.
- `latency`, 2: cycles from `fetch_next` high until the matching word is valid on `fetch_instruction`; range 1..4.
- `depth`, 4: skid buffer entries; must be at least `latency` + 1; power of two.

- `clk`  input  1: clock; all state changes on the rising edge.
- `rst`  input  1: reset; asynchronous, active-low.
- `fetch_instruction`  input  width: instruction word from the MMU, sampled exactly `latency` cycles after its request.
- `fetch_next`  output  1: pops one instruction from the MMU; wired to MMU `next`.
- `fetch_stop`  output  1: wired to MMU `stop`; equals `halted`.
- `flush`  input  1: synchronous flush request, one or more cycles.
- `out_ready`  input  1: execute stage accepts this cycle.
- `out_valid`  output  1: decoded instruction present.
- `out_raw`  output  width: undecoded word.
- `out_opcode`  output  6: bits [31:26].
- `out_rd`  output  5: bits [25:21].
- `out_rs1`  output  5: bits [20:16].
- `out_rs2`  output  5: bits [15:11].
- `out_imm`  output  32: bits [15:0], sign-extended.
- `halted`  output  1: a HALT has been issued; sticky until reset.

## Operation

- Credit flow control:
  - `inflight` is the count of set bits in a `latency`-deep request shift register.
  - `count` is the current buffer occupancy.
  - `fetch_next` = !`halted` && !`flush` && (`count` + `inflight`) < `depth`.
  - Because of this rule, a returning word always finds a free entry, so there is no overflow path.
- Request pipe:
  - Each cycle, the pipe shifts by one; the new bit is `fetch_next`.
  - When the bit leaving the pipe is 1, `fetch_instruction` is written at the buffer tail.
- Buffer: circular FIFO with wrapping read and write pointers.
  - `out_valid` = (`count` != 0) && !`halted`.
  - The decode fields are combinational from the head entry.
  - All `out_*` fields read 0 whenever `out_valid` = 0.
- Transfer: occurs when `out_valid` && `out_ready`; the head is popped.
  - A push and a pop in the same cycle leave `count` unchanged.
- HALT is opcode 6'h3F.
  - On a HALT transfer, `halted` is set on the same edge.
  - All remaining buffer entries and in-flight requests are discarded.
  - Words returned later are ignored.
  - Only reset clears `halted`.
- Flush, in any cycle with `flush` = 1:
  - The buffer is emptied.
  - Every request-pipe bit is cleared, so in-flight returns are dropped.
  - `fetch_next` = 0.
  - A transfer in the same cycle still completes: the consumer keeps that word, and HALT detection still applies to it.
  - Flush does not clear `halted`.
- Reset (`rst` low, asynchronous, at any time, including mid-request):
  - `count`, the pointers, the request pipe and `halted` are set to 0.
  - All outputs read 0.
  - Returns that arrive after reset release are ignored, because the pipe is empty.

## Timing

- If `fetch_next` is high in cycle N, the word is sampled at the edge ending cycle N+`latency`.
- `out_valid` is high from cycle N+`latency`+1 if the buffer was empty.
- Steady state with `out_ready` held 1: one instruction per cycle after the initial fill of `latency`+1 cycles.
- Backpressure with `out_ready` = 0:
  - Requests continue until `count` + `inflight` = `depth`, then `fetch_next` stays low.
  - After a pop, `fetch_next` rises in the next cycle; that cycle is combinational from the registered `count`.
- `halted`: rises on the edge that completes the HALT transfer. `out_valid` and `fetch_next` are low from the next cycle on.
- Flush: in the cycle after the flush edge, `count` = 0 and `out_valid` = 0. Requests resume in the first cycle with `flush` = 0.
- Reset values: `fetch_next` 0, `fetch_stop` 0, `out_valid` 0, `halted` 0, all `out_*` fields 0.

## Test plan

- Streaming:
  - Stimulus: MMU model with `latency` = 2 returning 32'h04210005, 32'h0862FFFF, ...; `out_ready` = 1.
  - Required: first `out_valid` 3 cycles after the first `fetch_next`; one word per cycle after that.
  - Required decode of the second word: `out_opcode` 2, `out_rd` 3, `out_rs1` 2, `out_rs2` 31, `out_imm` 32'hFFFFFFFF.
- Backpressure:
  - Stimulus: `out_ready` = 0 for 20 cycles, then 1.
  - Required: exactly 4 `fetch_next` pulses before the stall; no word lost or duplicated; output order matches request order across pointer wrap.
- HALT:
  - Stimulus: stream 3 normal words, then 32'hFC000000, then 2 more words.
  - Required: HALT transfers; `halted` = 1 and `fetch_stop` = 1 from the next cycle; `out_valid` stays 0 and `fetch_next` stays 0 thereafter.
- Flush mid-flight:
  - Stimulus: `flush` pulse for 1 cycle while 2 requests are in flight and 2 words are buffered.
  - Required: none of those 4 words ever appear at the output; the first word after the flush comes from the first post-flush request.
- Simultaneous events:
  - Stimulus: `flush` in the same cycle as a HALT transfer.
  - Required: the HALT is counted as transferred and `halted` sets.
- Mid-operation reset:
  - Stimulus: assert `rst` low asynchronously between clock edges with the buffer full.
  - Required: all outputs 0 immediately; after release, stale returns are ignored and fetch restarts cleanly.
